melody_tracker: RTL and testbench

- Sits downstream of the pitch detector and note filter, and consumes the thresholded 12-bit one-hot note (`t_note`).
- Steps through a fixed melody stored in ROM. It advances one position when the player holds the expected note for a minimum time.
- Counts hits and misses, and skips a note on timeout.
- Its outputs (index, expected note, score) feed the VGA staff renderer and the seven-segment display.

---
 rtl/note_pkg.sv | 48 ++++
 rtl/melody_rom.sv | 20 ++
 rtl/melody_tracker.sv | 154 +++++++++++++++
 tb/tb_melody_tracker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Note encodings, the stored melody and the tracker state type shared by the
// melody tracker and its ROM.
package note_pkg;

  localparam int w_note = 12;

  // One-hot pitch classes, C in the MSB down to B in the LSB.
  localparam logic [w_note-1:0] no_note = 12'b0000_0000_0000;
  localparam logic [w_note-1:0] C  = 12'b1000_0000_0000;
  localparam logic [w_note-1:0] Cs = 12'b0100_0000_0000;
  localparam logic [w_note-1:0] D  = 12'b0010_0000_0000;
  localparam logic [w_note-1:0] Ds = 12'b0001_0000_0000;
  localparam logic [w_note-1:0] E  = 12'b0000_1000_0000;
  localparam logic [w_note-1:0] F  = 12'b0000_0100_0000;
  localparam logic [w_note-1:0] Fs = 12'b0000_0010_0000;
  localparam logic [w_note-1:0] G  = 12'b0000_0001_0000;
  localparam logic [w_note-1:0] Gs = 12'b0000_0000_1000;
  localparam logic [w_note-1:0] A  = 12'b0000_0000_0100;
  localparam logic [w_note-1:0] As = 12'b0000_0000_0010;
  localparam logic [w_note-1:0] B  = 12'b0000_0000_0001;

  localparam logic [w_note-1:0] Df = Cs;
  localparam logic [w_note-1:0] Ef = Ds;
  localparam logic [w_note-1:0] Gf = Fs;
  localparam logic [w_note-1:0] Af = Gs;
  localparam logic [w_note-1:0] Bf = As;

  localparam int song_len = 62;

  localparam logic [w_note-1:0] melody [song_len] = '{
    E,  G,  D,  C,  D,  E,  E,  E,  D,  D,
    D,  E,  G,  G,  E,  D,  C,  D,  E,  E,
    E,  E,  D,  D,  E,  D,  C,  G,  A,  B,
    C,  B,  A,  G,  F,  E,  D,  C,  Cs, Ds,
    Fs, Gs, As, G,  F,  Ef, Df, Bf, Af, Gf,
    E,  G,  A,  G,  E,  D,  C,  D,  E,  G,
    D,  C
  };

  typedef enum logic [2:0] {
    IDLE,
    LISTEN,
    HOLD,
    RELEASE,
    DONE
  } state_t;

endpackage

// File: rtl/melody_rom.sv
// Combinational melody lookup; positions at or beyond song_len read as no_note.
module melody_rom #(
  parameter int song_len = note_pkg::song_len,
  parameter int w_idx    = $clog2(song_len + 1)
) (
  input  logic [w_idx-1:0]          idx,
  output logic [note_pkg::w_note-1:0] note
);
  import note_pkg::*;

  localparam int w_rom = $clog2(note_pkg::song_len);

  always_comb begin
    note = no_note;
    if (int'(idx) < song_len) begin
      note = melody[w_rom'(idx)];
    end
  end

endmodule

// File: rtl/melody_tracker.sv
// Walks the stored melody: a note scores when held long enough, wrong notes and
// timeouts count as misses, and repeated notes must be re-articulated.
module melody_tracker #(
  parameter int clk_mhz    = 50,
  parameter int song_len   = note_pkg::song_len,
  parameter int w_idx      = $clog2(song_len + 1),
  parameter int hold_ms    = 50,
  parameter int timeout_ms = 2000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [note_pkg::w_note-1:0] note_in,
  input  logic                        start,
  output logic [w_idx-1:0]            idx,
  output logic [note_pkg::w_note-1:0] expected_note,
  output logic                        hit,
  output logic                        miss,
  output logic [w_idx-1:0]            hits,
  output logic [w_idx-1:0]            misses,
  output logic                        busy,
  output logic                        done
);
  import note_pkg::*;

  localparam int prescale = clk_mhz * 1000;
  localparam int w_presc  = $clog2(prescale);
  localparam int w_hold   = $clog2(hold_ms + 1);
  localparam int w_to     = $clog2(timeout_ms + 1);
  localparam logic [w_idx-1:0] last_idx = w_idx'(song_len - 1);

  state_t             state;
  logic [w_presc-1:0] presc;
  logic [w_hold-1:0]  hold_cnt;
  logic [w_to-1:0]    timeout_cnt;
  logic [w_note-1:0]  last_wrong;
  logic [w_note-1:0]  held_note;
  logic               tick;
  logic               match;
  logic               wrong;
  logic               expire;
  logic               hold_done;

  function automatic logic [w_idx-1:0] sat_inc(input logic [w_idx-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  melody_rom #(
    .song_len(song_len),
    .w_idx   (w_idx)
  ) rom (
    .idx (idx),
    .note(expected_note)
  );

  // Free-running 1 ms tick; a restart does not realign it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  assign tick      = (presc == w_presc'(prescale - 1));
  assign match     = (note_in == expected_note) && (note_in != '0);
  // Multi-bit (non one-hot) inputs never equal a ROM entry, so they land here too.
  assign wrong     = (note_in != '0) && !match && (note_in != last_wrong);
  assign expire    = tick && (timeout_cnt == w_to'(timeout_ms - 1));
  assign hold_done = tick && (hold_cnt == w_hold'(hold_ms - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      hits        <= '0;
      misses      <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hold_cnt    <= '0;
      timeout_cnt <= '0;
      last_wrong  <= '0;
      held_note   <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (start) begin
        // Restart from any state; overrides a hit or timeout in the same cycle.
        state       <= LISTEN;
        idx         <= '0;
        hits        <= '0;
        misses      <= '0;
        hold_cnt    <= '0;
        timeout_cnt <= '0;
        last_wrong  <= '0;
        busy        <= 1'b1;
        done        <= 1'b0;
      end else begin
        case (state)
          LISTEN: begin
            if (note_in == '0) last_wrong <= '0;
            if (expire) begin
              miss        <= 1'b1;
              misses      <= sat_inc(misses);
              idx         <= idx + 1'b1;
              timeout_cnt <= '0;
              if (idx == last_idx) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              if (tick) timeout_cnt <= timeout_cnt + 1'b1;
              if (match) begin
                state    <= HOLD;
                hold_cnt <= '0;
              end else if (wrong) begin
                miss       <= 1'b1;
                misses     <= sat_inc(misses);
                last_wrong <= note_in;
              end
            end
          end
          HOLD: begin
            if (!match) begin
              state <= LISTEN;
            end else if (hold_done) begin
              hit         <= 1'b1;
              hits        <= sat_inc(hits);
              idx         <= idx + 1'b1;
              timeout_cnt <= '0;
              held_note   <= expected_note;
              if (idx == last_idx) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else if (tick) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (note_in != held_note) state <= LISTEN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_tracker.sv
// Directed bench for melody_tracker with a 1000-cycle ms tick, hold of 3 ticks,
// timeout of 10 ticks and a 5-note melody (E G D C D).
module tb_melody_tracker;
  import note_pkg::*;

  localparam int sl = 5;
  localparam int wi = $clog2(sl + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [w_note-1:0] note_in = '0;
  logic [w_note-1:0] expected_note;
  logic [wi-1:0]     idx, hits, misses;
  logic              hit, miss, busy, done;

  int checks = 0;
  int errors = 0;
  int hit_seen = 0;
  int miss_seen = 0;
  int h0 = 0;
  int m0 = 0;

  always #5 clk = ~clk;

  melody_tracker #(
    .clk_mhz   (1),
    .song_len  (sl),
    .w_idx     (wi),
    .hold_ms   (3),
    .timeout_ms(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .note_in      (note_in),
    .start        (start),
    .idx          (idx),
    .expected_note(expected_note),
    .hit          (hit),
    .miss         (miss),
    .hits         (hits),
    .misses       (misses),
    .busy         (busy),
    .done         (done)
  );

  always @(posedge clk) begin
    if (hit)  hit_seen  <= hit_seen + 1;
    if (miss) miss_seen <= miss_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    h0 = hit_seen;
    m0 = miss_seen;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // Reset in the middle of a hold
    pulse_start();
    note_in = E;
    step(500);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_idx", idx, 0);
    check("rst_hits", hits, 0);
    check("rst_misses", misses, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_expected", expected_note, E);
    mark();
    step(200);
    check("idle_hit_cnt", hit_seen - h0, 0);
    check("idle_busy", busy, 0);
    check("idle_idx", idx, 0);

    // First note held for three ticks
    mark();
    pulse_start();
    step(3500);
    check("e_hit_cnt", hit_seen - h0, 1);
    check("e_hits", hits, 1);
    check("e_idx", idx, 1);
    check("e_expected", expected_note, G);
    check("e_busy", busy, 1);
    mark();
    step(2000);
    check("e_held_hit_cnt", hit_seen - h0, 0);
    check("e_held_miss_cnt", miss_seen - m0, 0);

    // Wrong note, release, same wrong note again
    mark();
    note_in = A;  step(4);
    note_in = '0; step(4);
    note_in = A;  step(4);
    note_in = '0; step(1);
    check("wrong_misses", misses, 2);
    check("wrong_miss_cnt", miss_seen - m0, 2);
    check("wrong_idx", idx, 1);

    // Silence until the note times out
    mark();
    step(8000);
    check("to_early_miss_cnt", miss_seen - m0, 0);
    step(2600);
    check("to_miss_cnt", miss_seen - m0, 1);
    check("to_misses", misses, 3);
    check("to_idx", idx, 2);
    check("to_expected", expected_note, D);

    // Short hold does not score; a full hold after re-articulation does
    mark();
    note_in = D;  step(1500);
    check("short_hit_cnt", hit_seen - h0, 0);
    note_in = '0; step(4);
    note_in = D;  step(3500);
    check("long_hit_cnt", hit_seen - h0, 1);
    check("long_hits", hits, 2);
    check("long_idx", idx, 3);
    check("long_expected", expected_note, C);
    check("long_misses", misses, 3);

    // Held wrong note is penalised once; a chord counts as a new wrong note
    note_in = '0;
    pulse_start();
    mark();
    note_in = A;
    step(5500);
    check("held_wrong_miss_cnt", miss_seen - m0, 1);
    check("held_wrong_misses", misses, 1);
    check("held_wrong_idx", idx, 0);
    note_in = E | G;
    step(4);
    check("chord_misses", misses, 2);
    check("chord_idx", idx, 0);

    // Whole melody played correctly
    note_in = '0;
    pulse_start();
    for (int i = 0; i < sl; i++) begin
      int n;
      n = 0;
      mark();
      note_in = melody[i];
      while (hit_seen == h0 && n < 5000) begin
        step(1);
        n++;
      end
      check($sformatf("melody_hit_%0d", i), hit_seen - h0, 1);
      note_in = '0;
      step(3);
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_idx", idx, sl);
    check("end_hits", hits, sl);
    check("end_misses", misses, 0);
    check("end_expected", expected_note, no_note);
    pulse_start();
    check("restart_idx", idx, 0);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_hits", hits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
